// File: rtl/l1cache_assoc.sv
// N-way set-associative, write-back, write-allocate L1 cache with tree-PLRU replacement
// and an explicit flush that writes back every dirty line.
module l1cache_assoc #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 32,
  parameter int unsigned LINE_BYTES = 32,
  localparam int unsigned LINE_W    = 8 * LINE_BYTES
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              l1_read,
  input  logic              l1_write,
  input  logic [31:0]       l1_addr,
  input  logic [1:0]        l1_write_type,
  input  logic [31:0]       l1_write_data,
  input  logic              l1_flush,
  output logic [31:0]       l1_data_o,
  output logic              stall,
  output logic              l1_flush_done,
  output logic              l1_mmu_req_read,
  output logic              l1_mmu_req_write,
  output logic [31:0]       l1_mmu_req_addr,
  output logic [LINE_W-1:0] l1_mmu_write_data,
  input  logic              mmu_l1_read_done,
  input  logic              mmu_l1_write_done,
  input  logic [LINE_W-1:0] mmu_l1_read_data
);

  localparam int unsigned OB  = $clog2(LINE_BYTES);
  localparam int unsigned IB  = $clog2(SETS);
  localparam int unsigned TB  = 32 - OB - IB;
  localparam int unsigned WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned WOB = OB - 2;

  typedef enum logic [2:0] {StIdle, StWb, StFill, StFlush, StFlushWb} state_e;

  state_e state_q, state_d;
  logic [WW-1:0] victim_q, victim_d, fl_way_q, fl_way_d;
  logic [IB-1:0] fl_set_q, fl_set_d;
  logic          flush_done_q, flush_done_d;

  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [TB-1:0]     tag_q   [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [2:0]        plru_q  [SETS];

  logic [IB-1:0]     idx;
  logic [TB-1:0]     tag;
  logic [WOB-1:0]    woff;
  logic              hit, inv_found;
  logic [WW-1:0]     hit_way, inv_way, vic;
  logic [LINE_W-1:0] hit_line, new_line;
  logic [31:0]       hit_word, new_word, wrep;
  logic [3:0]        be;
  logic              touch, wr_hit, fill_done, flush_clean, fl_adv;

  // Tree bits point at the next victim: bit0 selects the half, bit1/bit2 the way within it.
  function automatic logic [2:0] plru_touch(input logic [2:0] cur, input logic [1:0] w);
    logic [2:0] r;
    r = cur;
    if (WAYS == 2) begin
      r[0] = ~w[0];
    end else if (WAYS == 4) begin
      r[0] = ~w[1];
      if (w[1]) r[2] = ~w[0];
      else      r[1] = ~w[0];
    end
    return r;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] p);
    if (WAYS == 2)      return {1'b0, p[0]};
    else if (WAYS == 4) return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    else                return 2'b00;
  endfunction

  assign idx  = l1_addr[OB+IB-1:OB];
  assign tag  = l1_addr[31:OB+IB];
  assign woff = l1_addr[OB-1:2];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  assign hit_line = data_q[hit_way][idx];
  assign hit_word = hit_line[{woff, 5'd0} +: 32];

  always_comb begin
    unique case (l1_write_type)
      2'b01: begin
        be   = l1_addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{l1_write_data[15:0]}};
      end
      2'b10: begin
        be   = 4'b0001 << l1_addr[1:0];
        wrep = {4{l1_write_data[7:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = l1_write_data;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      new_word[8*b +: 8] = be[b] ? wrep[8*b +: 8] : hit_word[8*b +: 8];
    end
    new_line = hit_line;
    new_line[{woff, 5'd0} +: 32] = new_word;
  end

  always_comb begin
    state_d           = state_q;
    victim_d          = victim_q;
    fl_set_d          = fl_set_q;
    fl_way_d          = fl_way_q;
    flush_done_d      = 1'b0;
    touch             = 1'b0;
    wr_hit            = 1'b0;
    fill_done         = 1'b0;
    flush_clean       = 1'b0;
    fl_adv            = 1'b0;
    l1_mmu_req_read   = 1'b0;
    l1_mmu_req_write  = 1'b0;
    l1_mmu_req_addr   = '0;
    l1_mmu_write_data = '0;
    vic = inv_found ? inv_way : WW'(plru_victim(plru_q[idx]));
    unique case (state_q)
      StIdle: begin
        if (l1_read || l1_write) begin
          if (hit) begin
            touch  = 1'b1;
            wr_hit = l1_write;
          end else begin
            victim_d = vic;
            state_d  = (valid_q[vic][idx] && dirty_q[vic][idx]) ? StWb : StFill;
          end
        end else if (l1_flush) begin
          fl_set_d = '0;
          fl_way_d = '0;
          state_d  = StFlush;
        end
      end
      StWb: begin
        l1_mmu_req_write  = 1'b1;
        l1_mmu_req_addr   = {tag_q[victim_q][idx], idx, {OB{1'b0}}};
        l1_mmu_write_data = data_q[victim_q][idx];
        if (mmu_l1_write_done) state_d = StFill;
      end
      StFill: begin
        l1_mmu_req_read = 1'b1;
        l1_mmu_req_addr = {l1_addr[31:OB], {OB{1'b0}}};
        if (mmu_l1_read_done) begin
          fill_done = 1'b1;
          state_d   = StIdle;
        end
      end
      StFlush: begin
        if (valid_q[fl_way_q][fl_set_q] && dirty_q[fl_way_q][fl_set_q]) state_d = StFlushWb;
        else fl_adv = 1'b1;
      end
      StFlushWb: begin
        l1_mmu_req_write  = 1'b1;
        l1_mmu_req_addr   = {tag_q[fl_way_q][fl_set_q], fl_set_q, {OB{1'b0}}};
        l1_mmu_write_data = data_q[fl_way_q][fl_set_q];
        if (mmu_l1_write_done) begin
          flush_clean = 1'b1;
          fl_adv      = 1'b1;
          state_d     = StFlush;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fl_adv) begin
      if (fl_way_q == WW'(WAYS - 1)) begin
        fl_way_d = '0;
        if (fl_set_q == IB'(SETS - 1)) begin
          state_d      = StIdle;
          flush_done_d = 1'b1;
        end else begin
          fl_set_d = fl_set_q + 1'b1;
        end
      end else begin
        fl_way_d = fl_way_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      victim_q     <= '0;
      fl_set_q     <= '0;
      fl_way_q     <= '0;
      flush_done_q <= 1'b0;
      for (int w = 0; w < int'(WAYS); w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      fl_set_q     <= fl_set_d;
      fl_way_q     <= fl_way_d;
      flush_done_q <= flush_done_d;
      if (touch) plru_q[idx] <= plru_touch(plru_q[idx], 2'(hit_way));
      if (wr_hit) dirty_q[hit_way][idx] <= 1'b1;
      if (fill_done) begin
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
        plru_q[idx]            <= plru_touch(plru_q[idx], 2'(victim_q));
      end
      if (flush_clean) dirty_q[fl_way_q][fl_set_q] <= 1'b0;
    end
  end

  // Line payload and tags carry no reset; valid bits qualify them.
  always_ff @(posedge sys_clk) begin
    if (wr_hit) data_q[hit_way][idx] <= new_line;
    if (fill_done) begin
      data_q[victim_q][idx] <= mmu_l1_read_data;
      tag_q[victim_q][idx]  <= tag;
    end
  end

  assign l1_data_o     = hit ? hit_word : 32'h0;
  assign stall         = ~rst & ((state_q != StIdle) | ((l1_read | l1_write) & ~hit));
  assign l1_flush_done = flush_done_q;

endmodule

// File: tb/tb_l1cache_assoc.sv
// Bench for l1cache_assoc: 3-cycle MMU model, LRU reference model of resident lines,
// directed scenarios plus randomized load/store traffic.
module tb_l1cache_assoc;

  localparam int unsigned WAYS = 2, SETS = 32, LINE_BYTES = 32, LINE_W = 256, LAT = 3;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              l1_read = 1'b0, l1_write = 1'b0, l1_flush = 1'b0;
  logic [31:0]       l1_addr = '0, l1_write_data = '0;
  logic [1:0]        l1_write_type = '0;
  logic [31:0]       l1_data_o, l1_mmu_req_addr;
  logic              stall, l1_flush_done, l1_mmu_req_read, l1_mmu_req_write;
  logic [LINE_W-1:0] l1_mmu_write_data;
  logic              mmu_l1_read_done = 1'b0, mmu_l1_write_done = 1'b0;
  logic [LINE_W-1:0] mmu_l1_read_data = '0;

  always #5 sys_clk = ~sys_clk;

  l1cache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES)) dut (
    .sys_clk(sys_clk), .rst(rst), .l1_read(l1_read), .l1_write(l1_write), .l1_addr(l1_addr),
    .l1_write_type(l1_write_type), .l1_write_data(l1_write_data), .l1_flush(l1_flush),
    .l1_data_o(l1_data_o), .stall(stall), .l1_flush_done(l1_flush_done),
    .l1_mmu_req_read(l1_mmu_req_read), .l1_mmu_req_write(l1_mmu_req_write),
    .l1_mmu_req_addr(l1_mmu_req_addr), .l1_mmu_write_data(l1_mmu_write_data),
    .mmu_l1_read_done(mmu_l1_read_done), .mmu_l1_write_done(mmu_l1_write_done),
    .mmu_l1_read_data(mmu_l1_read_data)
  );

  int unsigned n_checks = 0, n_pass = 0;

  // ---------------- MMU model ----------------
  logic [31:0]       mmu_mem [int unsigned];
  int unsigned       mmu_reads = 0, mmu_writes = 0, mmu_cnt = 0, done_cnt = 0;
  logic [31:0]       rd_addrs[$], wr_addrs[$];
  logic [LINE_W-1:0] last_wdata = '0;
  bit                overlap_seen = 0;

  function automatic logic [31:0] init_word(int unsigned wa);
    return 32'(wa * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  function automatic logic [31:0] mem_rd(int unsigned wa);
    return mmu_mem.exists(wa) ? mmu_mem[wa] : init_word(wa);
  endfunction

  always begin
    @(posedge sys_clk);
    #1;
    mmu_l1_read_done  = 1'b0;
    mmu_l1_write_done = 1'b0;
    if (l1_mmu_req_read && l1_mmu_req_write) overlap_seen = 1;
    if (rst || !(l1_mmu_req_read || l1_mmu_req_write)) begin
      mmu_cnt = 0;
    end else begin
      mmu_cnt++;
      if (mmu_cnt == LAT) begin
        mmu_cnt = 0;
        if (l1_mmu_req_write) begin
          mmu_writes++;
          wr_addrs.push_back(l1_mmu_req_addr);
          last_wdata = l1_mmu_write_data;
          for (int i = 0; i < 8; i++) mmu_mem[(l1_mmu_req_addr >> 2) + i] = l1_mmu_write_data[i*32 +: 32];
          mmu_l1_write_done = 1'b1;
        end else begin
          mmu_reads++;
          rd_addrs.push_back(l1_mmu_req_addr);
          for (int i = 0; i < 8; i++) mmu_l1_read_data[i*32 +: 32] = mem_rd((l1_mmu_req_addr >> 2) + i);
          mmu_l1_read_done = 1'b1;
        end
      end
    end
  end

  always @(negedge sys_clk) if (l1_flush_done) done_cnt++;

  // ---------------- Reference model: resident lines per set, LRU at the front ----------------
  int unsigned set_lines [SETS][$];
  bit          dirty_m [int unsigned];
  logic [31:0] golden [int unsigned];

  function automatic logic [31:0] gold_rd(int unsigned wa);
    return golden.exists(wa) ? golden[wa] : mem_rd(wa);
  endfunction

  function automatic void reset_model();
    for (int s = 0; s < int'(SETS); s++) set_lines[s].delete();
    dirty_m.delete();
    golden.delete();
  endfunction

  function automatic void model_access(input bit wr, input logic [31:0] addr, input logic [1:0] wt,
                                       input logic [31:0] wd, output bit hit, output bit wb,
                                       output logic [31:0] wb_addr, output logic [31:0] rd);
    int unsigned line, set, vic, sh;
    logic [31:0] w, m;
    line = addr & 32'hFFFF_FFE0;
    set = (addr >> 5) % SETS;
    hit = 0; wb = 0; wb_addr = '0;
    for (int i = 0; i < set_lines[set].size(); i++) begin
      if (set_lines[set][i] == line) begin
        hit = 1;
        set_lines[set].delete(i);
        break;
      end
    end
    if (!hit && set_lines[set].size() == WAYS) begin
      vic = set_lines[set].pop_front();
      if (dirty_m.exists(vic)) begin
        wb = 1; wb_addr = vic;
        dirty_m.delete(vic);
      end
    end
    set_lines[set].push_back(line);
    rd = gold_rd(addr >> 2);
    if (wr) begin
      w = rd;
      case (wt)
        2'b01: begin
          sh = addr[1] ? 16 : 0; m = 32'hFFFF << sh;
          w = (w & ~m) | ((wd & 32'hFFFF) << sh);
        end
        2'b10: begin
          sh = 8 * int'(addr[1:0]); m = 32'hFF << sh;
          w = (w & ~m) | ((wd & 32'hFF) << sh);
        end
        default: w = wd;
      endcase
      golden[addr >> 2] = w;
      dirty_m[line] = 1;
    end
  endfunction

  // ---------------- Drivers ----------------
  task automatic do_reset();
    @(posedge sys_clk); #2;
    rst = 1'b1; l1_read = 1'b0; l1_write = 1'b0; l1_flush = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2 rst = 1'b0;
    reset_model();
  endtask

  task automatic cpu_op(input bit wr, input bit both, input logic [31:0] addr, input logic [1:0] wt,
                        input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    @(posedge sys_clk); #1;
    l1_read = !wr || both; l1_write = wr; l1_addr = addr; l1_write_type = wt; l1_write_data = wd;
    cyc = 0;
    @(negedge sys_clk);
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge sys_clk);
    end
    rd = l1_data_o;
    @(posedge sys_clk); #1;
    l1_read = 1'b0; l1_write = 1'b0;
  endtask

  task automatic run_op(input bit wr, input bit both, input logic [31:0] addr, input logic [1:0] wt,
                        input logic [31:0] wd, output bit e_hit, output bit e_wb,
                        output logic [31:0] e_wb_addr, output logic [31:0] e_rd,
                        output logic [31:0] rd, output int cyc, output int dr, output int dw);
    int unsigned r0, w0;
    model_access(wr, addr, wt, wd, e_hit, e_wb, e_wb_addr, e_rd);
    r0 = mmu_reads; w0 = mmu_writes;
    cpu_op(wr, both, addr, wt, wd, rd, cyc);
    dr = int'(mmu_reads - r0); dw = int'(mmu_writes - w0);
  endtask

  task automatic do_flush(output int cyc, output int stall_low);
    @(posedge sys_clk); #1 l1_flush = 1'b1;
    @(posedge sys_clk); #1 l1_flush = 1'b0;
    cyc = 0; stall_low = 0;
    @(negedge sys_clk);
    while (!l1_flush_done && cyc < 2000) begin
      if (!stall) stall_low++;
      cyc++;
      @(negedge sys_clk);
    end
    repeat (3) @(negedge sys_clk);
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (l1_mmu_req_read !== 1'b0) $display("FAIL reset_req_read: got %b want 0", l1_mmu_req_read); else n_pass++;
    n_checks++; if (l1_mmu_req_write !== 1'b0) $display("FAIL reset_req_write: got %b want 0", l1_mmu_req_write); else n_pass++;
    n_checks++; if (l1_flush_done !== 1'b0) $display("FAIL reset_flush_done: got %b want 0", l1_flush_done); else n_pass++;
    n_checks++; if (l1_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", l1_data_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_cold_read();
    bit h, wb; logic [31:0] wa, e, rd; int cyc, dr, dw;
    do_reset();
    run_op(0, 0, 32'h0000_000C, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (cyc != 1 + LAT) $display("FAIL cold_stall_cycles: got %0d want %0d", cyc, 1 + LAT); else n_pass++;
    n_checks++; if (dr != 1) $display("FAIL cold_fill_count: got %0d want 1", dr); else n_pass++;
    n_checks++; if (rd_addrs[$] !== 32'h0) $display("FAIL cold_fill_addr: got %h want 0", rd_addrs[$]); else n_pass++;
    n_checks++; if (rd !== init_word(3)) $display("FAIL cold_data: got %h want %h", rd, init_word(3)); else n_pass++;
    run_op(0, 0, 32'h0000_000C, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (cyc != 0) $display("FAIL reread_stall: got %0d want 0", cyc); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL reread_data: got %h want %h", rd, e); else n_pass++;
  endtask

  task automatic test_conflict();
    bit h, wb; logic [31:0] wa, e, rd; int cyc, dr, dw; int unsigned w0;
    logic [31:0] seq [4];
    seq = '{32'h000, 32'h400, 32'h000, 32'h800};
    do_reset();
    w0 = mmu_writes;
    foreach (seq[i]) run_op(0, 0, seq[i], 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (mmu_writes != w0) $display("FAIL conflict_no_wb: got %0d want 0", mmu_writes - w0); else n_pass++;
    run_op(0, 0, 32'h000, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (cyc != 0) $display("FAIL conflict_mru_hit: stall %0d want 0", cyc); else n_pass++;
    run_op(0, 0, 32'h400, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (cyc != 1 + LAT || dr != 1) $display("FAIL conflict_lru_evicted: stall %0d fills %0d want %0d 1", cyc, dr, 1 + LAT); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL conflict_data: got %h want %h", rd, e); else n_pass++;
  endtask

  task automatic test_dirty_evict();
    bit h, wb; logic [31:0] wa, e, rd; int cyc, dr, dw;
    do_reset();
    run_op(1, 0, 32'h00C, 2'b00, 32'hAAAA_BBBB, h, wb, wa, e, rd, cyc, dr, dw);
    run_op(0, 0, 32'h400, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    run_op(0, 0, 32'h800, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (cyc != 1 + 2 * LAT) $display("FAIL evict_stall_cycles: got %0d want %0d", cyc, 1 + 2 * LAT); else n_pass++;
    n_checks++; if (dw != 1) $display("FAIL evict_wb_count: got %0d want 1", dw); else n_pass++;
    n_checks++; if (wr_addrs[$] !== 32'h000) $display("FAIL evict_wb_addr: got %h want 0", wr_addrs[$]); else n_pass++;
    n_checks++; if (last_wdata[127:96] !== 32'hAAAA_BBBB) $display("FAIL evict_wb_data: got %h want aaaabbbb", last_wdata[127:96]); else n_pass++;
    n_checks++; if (dr != 1 || rd_addrs[$] !== 32'h800) $display("FAIL evict_fill: count %0d addr %h want 1 800", dr, rd_addrs[$]); else n_pass++;
  endtask

  task automatic test_partial_stores();
    bit h, wb; logic [31:0] wa, e, rd; int cyc, dr, dw;
    do_reset();
    run_op(1, 0, 32'h000, 2'b00, 32'h1111_2222, h, wb, wa, e, rd, cyc, dr, dw);
    run_op(1, 0, 32'h003, 2'b01, 32'hFFFF_1234, h, wb, wa, e, rd, cyc, dr, dw);
    run_op(0, 0, 32'h000, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (rd !== 32'h1234_2222) $display("FAIL store_half: got %h want 12342222", rd); else n_pass++;
    run_op(1, 1, 32'h001, 2'b10, 32'h5566_77AB, h, wb, wa, e, rd, cyc, dr, dw);
    run_op(0, 0, 32'h000, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (rd !== 32'h1234_AB22) $display("FAIL store_byte: got %h want 1234ab22", rd); else n_pass++;
    run_op(1, 0, 32'h002, 2'b11, 32'hDEAD_BEEF, h, wb, wa, e, rd, cyc, dr, dw);
    run_op(0, 0, 32'h000, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL store_reserved_as_word: got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_flush();
    bit h, wb; logic [31:0] wa, e, rd; int cyc, dr, dw, fc, sl; int unsigned w0, d0;
    do_reset();
    run_op(1, 0, 32'h000, 2'b00, 32'hCAFE_0001, h, wb, wa, e, rd, cyc, dr, dw);
    run_op(1, 0, 32'h424, 2'b00, 32'hCAFE_0002, h, wb, wa, e, rd, cyc, dr, dw);
    run_op(0, 0, 32'h040, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    w0 = mmu_writes; d0 = done_cnt;
    do_flush(fc, sl);
    dirty_m.delete();
    n_checks++; if (mmu_writes - w0 != 2) $display("FAIL flush_wb_count: got %0d want 2", mmu_writes - w0); else n_pass++;
    n_checks++; if (done_cnt - d0 != 1) $display("FAIL flush_done_pulses: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (sl != 0 || fc >= 2000) $display("FAIL flush_stall: low %0d cycles %0d want 0 <2000", sl, fc); else n_pass++;
    n_checks++; if (mem_rd(32'h424 >> 2) !== 32'hCAFE_0002) $display("FAIL flush_wb_data: got %h want cafe0002", mem_rd(32'h424 >> 2)); else n_pass++;
    run_op(0, 0, 32'h000, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (cyc != 0 || dr != 0 || dw != 0) $display("FAIL flush_rehit_0: stall %0d rd %0d wr %0d want 0 0 0", cyc, dr, dw); else n_pass++;
    run_op(0, 0, 32'h424, 2'b00, '0, h, wb, wa, e, rd, cyc, dr, dw);
    n_checks++; if (cyc != 0 || dr != 0 || rd !== 32'hCAFE_0002) $display("FAIL flush_rehit_424: stall %0d rd %0d data %h want 0 0 cafe0002", cyc, dr, rd); else n_pass++;
  endtask

  task automatic test_reset_during_fill();
    bit h, wb; logic [31:0] wa, e; int cyc; int unsigned r0;
    do_reset();
    r0 = mmu_reads;
    @(posedge sys_clk); #1;
    l1_read = 1'b1; l1_write = 1'b0; l1_addr = 32'h0000_000C;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++; if (l1_mmu_req_read !== 1'b1) $display("FAIL rstfill_in_fill: got %b want 1", l1_mmu_req_read); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({l1_mmu_req_read, l1_mmu_req_write, stall} !== 3'b000) $display("FAIL rstfill_outputs: got %b want 000", {l1_mmu_req_read, l1_mmu_req_write, stall}); else n_pass++;
    n_checks++; if (l1_data_o !== 32'h0) $display("FAIL rstfill_data: got %h want 0", l1_data_o); else n_pass++;
    repeat (2) @(posedge sys_clk);
    #2 rst = 1'b0;
    reset_model();
    model_access(0, 32'h0000_000C, 2'b00, '0, h, wb, wa, e);
    cyc = 0;
    @(negedge sys_clk);
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge sys_clk);
    end
    n_checks++; if (cyc != 1 + LAT) $display("FAIL rstfill_refetch_stall: got %0d want %0d", cyc, 1 + LAT); else n_pass++;
    n_checks++; if (mmu_reads - r0 != 1 || rd_addrs[$] !== 32'h0) $display("FAIL rstfill_refetch: fills %0d addr %h want 1 0", mmu_reads - r0, rd_addrs[$]); else n_pass++;
    n_checks++; if (l1_data_o !== e) $display("FAIL rstfill_data_after: got %h want %h", l1_data_o, e); else n_pass++;
    @(posedge sys_clk); #1 l1_read = 1'b0;
  endtask

  task automatic test_random();
    bit h, wb, wr; logic [31:0] wa, e, rd, addr, wd; logic [1:0] wt;
    int cyc, dr, dw, fc, sl, exp_cyc; int unsigned w0, nd;
    do_reset();
    for (int n = 0; n < 250; n++) begin
      addr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31);
      wr = ($urandom_range(0, 9) < 4);
      wt = 2'($urandom_range(0, 3));
      wd = $urandom;
      run_op(wr, 0, addr, wt, wd, h, wb, wa, e, rd, cyc, dr, dw);
      exp_cyc = h ? 0 : 1 + int'(LAT) * (1 + int'(wb));
      n_checks++; if (cyc != exp_cyc) $display("FAIL rand_stall @%h: got %0d want %0d", addr, cyc, exp_cyc); else n_pass++;
      n_checks++; if (dr != int'(!h) || dw != int'(wb)) $display("FAIL rand_traffic @%h: rd %0d wr %0d want %0d %0d", addr, dr, dw, !h, wb); else n_pass++;
      if (!wr) begin
        n_checks++; if (rd !== e) $display("FAIL rand_data @%h: got %h want %h", addr, rd, e); else n_pass++;
      end
      if (wb) begin
        n_checks++; if (wr_addrs[$] !== wa) $display("FAIL rand_wb_addr: got %h want %h", wr_addrs[$], wa); else n_pass++;
      end
    end
    nd = dirty_m.num();
    w0 = mmu_writes;
    do_flush(fc, sl);
    dirty_m.delete();
    n_checks++; if (mmu_writes - w0 != nd) $display("FAIL rand_flush_wb_count: got %0d want %0d", mmu_writes - w0, nd); else n_pass++;
    foreach (golden[k]) begin
      n_checks++; if (mem_rd(k) !== golden[k]) $display("FAIL rand_mem_word %h: got %h want %h", k << 2, mem_rd(k), golden[k]); else n_pass++;
    end
  endtask

  task automatic test_protocol();
    n_checks++; if (overlap_seen !== 1'b0) $display("FAIL req_overlap: got %b want 0", overlap_seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_conflict();
    test_dirty_evict();
    test_partial_stores();
    test_flush();
    test_reset_during_fill();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
